ras_predictor: RTL
==================

// Module: ras_predictor
// PURPOSE
//  Parametrised return-address-stack predictor for the RV32 fetch path; drives the PC mux.
//  Classifies JAL/JALR using the RISC-V link-register hint table (x1/x5), then
//  pushes, pops or does both (coroutine swap) on a circular stack.
//  Registered outputs:
//  - push/pop are status outputs only; no external stack handshake.
//  - pc_jmp carries the predicted target.
//  Additions: overflow wrap and underflow detection, plus a pointer checkpoint/restore
//  path for pipeline flushes.
// PARAMETERS
//  XLEN   32  address width
//  DEPTH  8   stack entries; power of 2, >=2
//  PTR_W  $clog2(DEPTH)  derived, not overridable
// PORTS
//  clk          in   1      rising-edge clock
//  reset_in     in   1      asynchronous, active-high reset
//  valid_in     in   1      instruction fields below are valid this cycle
//  opcode       in   7      instruction opcode
//  rd           in   5      destination register
//  rs1          in   5      source register 1
//  pc           in   XLEN   instruction PC
//  imm_in       in   XLEN   sign-extended immediate
//  recover_in   in   1      flush: restore pointer state
//  recover_tos  in   PTR_W  TOS pointer to restore
//  recover_cnt  in   PTR_W+1 occupancy to restore
//  ckpt_tos     out  PTR_W  TOS pointer before the current instruction (combinational)
//  ckpt_cnt     out  PTR_W+1 occupancy before the current instruction (combinational)
//  pred_valid   out  1      pc_jmp is a real prediction
//  pc_jmp       out  XLEN   predicted next PC; pc+4 when pred_valid=0
//  push         out  1      push performed
//  pop          out  1      pop performed
//  overflow     out  1      push overwrote the oldest entry
//  underflow    out  1      pop attempted on an empty stack
// BEHAVIOUR
//  Reset: tos=0, cnt=0, all registered outputs 0, pc_jmp=0. Stack contents are not reset.
//  Link register: link(r) = (r==1 || r==5).
//  Classification, opcode 1101111 (JAL):
//  - link(rd): PUSH.
//  - otherwise: NONE.
//  Classification, opcode 1100111 (JALR):
//  - link(rd) && !link(rs1): PUSH.
//  - !link(rd) && link(rs1): POP.
//  - link(rd) && link(rs1) && rd==rs1: PUSH.
//  - link(rd) && link(rs1) && rd!=rs1: POPPUSH.
//  - neither: NONE.
//  Any other opcode, or valid_in=0: NONE.
//  Latency: one cycle. Fields sampled at edge N; outputs valid after edge N; stack updated at edge N.
//  Push value: pc+4, mod 2^XLEN. All pointer arithmetic is mod DEPTH.
//  PUSH:
//  - mem[tos+1]=pc+4; tos=tos+1; cnt=min(cnt+1,DEPTH).
//  - If cnt was DEPTH: oldest entry is overwritten, overflow=1.
//  - JAL: pred_valid=1, pc_jmp=pc+imm_in.
//  - JALR: pred_valid=0, pc_jmp=pc+4.
//  POP:
//  - cnt>0: pc_jmp=mem[tos], pred_valid=1, tos=tos-1, cnt=cnt-1.
//  - cnt==0: underflow=1, pred_valid=0, pc_jmp=pc+4; tos and cnt unchanged; pop=0.
//  POPPUSH:
//  - Target is mem[tos] (pred_valid=cnt>0).
//  - Same cycle, mem[tos]=pc+4; tos and cnt unchanged.
//  - When cnt==0: acts as PUSH with pred_valid=0 and underflow=1.
//  - push=1; pop=(cnt>0).
//  NONE: push=pop=pred_valid=overflow=underflow=0, pc_jmp=pc+4.
//  recover_in:
//  - Has priority over valid_in in the same cycle; the instruction is dropped.
//  - tos=recover_tos; cnt=recover_cnt. Outputs are those of NONE.
//  - recover_cnt>DEPTH is clamped to DEPTH.
//  Status pulses: overflow and underflow are single-cycle pulses.
//  Read-during-write: next-cycle pop reads the value pushed this cycle (write-first).
//  Async reset mid-operation: state and outputs go to reset values immediately.
// STRUCTURE
//  ras_pkg:
//  - OPC_JAL and OPC_JALR constants.
//  - LINK_X1 and LINK_X5 constants.
//  - Action enum: NONE, PUSH, POP, POPPUSH.
//  ras_stack_mem sub-module:
//  - DEPTH x XLEN register array.
//  - One write port; one async read port at tos.
//  - No reset.
//  Top level: classifier (combinational), pointer/count registers, output registers.
// TESTING
//  1. Reset, then JAL rd=1, pc=0x100, imm=0x40 -> push=1, pred_valid=1, pc_jmp=0x140, cnt=1;
//     then JALR rs1=1, rd=0 -> pop=1, pc_jmp=0x104, cnt=0.
//  2. DEPTH=8: 9 JAL rd=1 pushes at pc=0x0,0x10,...,0x80 -> 9th has overflow=1, cnt=8;
//     8 pops return 0x84 down to 0x14; 9th pop gives underflow=1, pc_jmp=pc+4.
//  3. JAL rd=1 at pc=0x200, then JALR rd=5, rs1=1 at pc=0x300 -> pop=push=1, pc_jmp=0x204;
//     next JALR rs1=5, rd=0 -> pc_jmp=0x304.
//  4. Push 0xA0, capture ckpt_tos/cnt; push 0xB0, 0xC0; recover_in with captured values
//     plus valid_in=1 -> instruction ignored; next pop returns 0xA0+4.
//  5. JALR rd=1, rs1=1 -> PUSH, pred_valid=0, pc_jmp=pc+4.
//     Opcode 0110011 -> all status 0.
//  6. reset_in asserted asynchronously between edges after 3 pushes -> outputs 0
//     immediately; subsequent pop gives underflow=1.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared constants, action encoding and the link-register classifier for the RAS predictor.
`default_nettype none

package ras_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [4:0] LINK_X1  = 5'd1;
  localparam logic [4:0] LINK_X5  = 5'd5;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PUSH    = 2'd1,
    POP     = 2'd2,
    POPPUSH = 2'd3
  } ras_action_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

  function automatic ras_action_e classify(input logic       valid,
                                           input logic [6:0] opcode,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1);
    ras_action_e act;
    logic        l_rd;
    logic        l_rs1;
    act   = NONE;
    l_rd  = is_link(rd);
    l_rs1 = is_link(rs1);
    if (valid && opcode == OPC_JAL) begin
      if (l_rd) act = PUSH;
    end else if (valid && opcode == OPC_JALR) begin
      if (l_rd && !l_rs1)      act = PUSH;
      else if (!l_rd && l_rs1) act = POP;
      else if (l_rd && l_rs1)  act = (rd == rs1) ? PUSH : POPPUSH;
    end
    return act;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ras_predictor_if.sv
// Instruction, recovery and prediction signals between fetch logic and the RAS predictor.
`default_nettype none

interface ras_predictor_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             valid_in;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm_in;
  logic             recover_in;
  logic [PTR_W-1:0] recover_tos;
  logic [PTR_W:0]   recover_cnt;
  logic [PTR_W-1:0] ckpt_tos;
  logic [PTR_W:0]   ckpt_cnt;
  logic             pred_valid;
  logic [XLEN-1:0]  pc_jmp;
  logic             push;
  logic             pop;
  logic             overflow;
  logic             underflow;

  modport master (
    output valid_in, opcode, rd, rs1, pc, imm_in, recover_in, recover_tos, recover_cnt,
    input  ckpt_tos, ckpt_cnt, pred_valid, pc_jmp, push, pop, overflow, underflow
  );

  modport slave (
    input  valid_in, opcode, rd, rs1, pc, imm_in, recover_in, recover_tos, recover_cnt,
    output ckpt_tos, ckpt_cnt, pred_valid, pc_jmp, push, pop, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/ras_stack_mem.sv
// Return-address storage: single write port, asynchronous read at the top of stack.
`default_nettype none

module ras_stack_mem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     we_i,
  input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
  input  wire logic [XLEN-1:0]          wdata_i,
  input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic      [XLEN-1:0]          rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/ras_predictor.sv
// Return-address-stack predictor: classifies JAL/JALR by link hints and drives the predicted PC.
`default_nettype none

module ras_predictor
  import ras_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  wire logic     clk,
  input  wire logic     reset_in,
  ras_predictor_if.slave bus
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] TOS_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [XLEN-1:0]  INSN_SZ = XLEN'(4);

  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic             pred_valid_q, pred_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [XLEN-1:0]  pc_jmp_q, pc_jmp_d;

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [XLEN-1:0]  mem_rdata;
  logic [XLEN-1:0]  link_addr;
  logic             do_push;
  logic             empty;
  logic             full;
  ras_action_e      action;

  assign link_addr = bus.pc + INSN_SZ;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_MAX);
  assign action    = classify(bus.valid_in, bus.opcode, bus.rd, bus.rs1);

  ras_stack_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (link_addr),
    .raddr_i (tos_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    tos_d        = tos_q;
    cnt_d        = cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = tos_q + TOS_ONE;
    do_push      = 1'b0;
    push_d       = 1'b0;
    pop_d        = 1'b0;
    pred_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    pc_jmp_d     = link_addr;

    if (bus.recover_in) begin
      tos_d = bus.recover_tos;
      cnt_d = (bus.recover_cnt > CNT_MAX) ? CNT_MAX : bus.recover_cnt;
    end else begin
      unique case (action)
        PUSH: begin
          do_push = 1'b1;
          if (bus.opcode == OPC_JAL) begin
            pred_valid_d = 1'b1;
            pc_jmp_d     = bus.pc + bus.imm_in;
          end
        end
        POP: begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            pop_d        = 1'b1;
            pred_valid_d = 1'b1;
            pc_jmp_d     = mem_rdata;
            tos_d        = tos_q - TOS_ONE;
            cnt_d        = cnt_q - CNT_ONE;
          end
        end
        POPPUSH: begin
          if (empty) begin
            // Nothing to swap with: degrade to a plain push and flag the missed pop.
            do_push     = 1'b1;
            underflow_d = 1'b1;
          end else begin
            // Coroutine swap: read the old top and overwrite it in the same slot.
            pop_d        = 1'b1;
            push_d       = 1'b1;
            pred_valid_d = 1'b1;
            pc_jmp_d     = mem_rdata;
            mem_we       = 1'b1;
            mem_waddr    = tos_q;
          end
        end
        default: ;
      endcase

      if (do_push) begin
        mem_we = 1'b1;
        push_d = 1'b1;
        tos_d  = tos_q + TOS_ONE;
        if (full) overflow_d = 1'b1;
        else      cnt_d      = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      tos_q        <= '0;
      cnt_q        <= '0;
      push_q       <= 1'b0;
      pop_q        <= 1'b0;
      pred_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      pc_jmp_q     <= '0;
    end else begin
      tos_q        <= tos_d;
      cnt_q        <= cnt_d;
      push_q       <= push_d;
      pop_q        <= pop_d;
      pred_valid_q <= pred_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      pc_jmp_q     <= pc_jmp_d;
    end
  end

  assign bus.ckpt_tos   = tos_q;
  assign bus.ckpt_cnt   = cnt_q;
  assign bus.push       = push_q;
  assign bus.pop        = pop_q;
  assign bus.pred_valid = pred_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.pc_jmp     = pc_jmp_q;

endmodule

`default_nettype wire
